// File: rtl/fa_chk_pkg.sv
// Shared types and helpers for the full-adder response checker.
//   state_e : checker FSM states
//   COV_ALL : coverage mask with every {a,b,cin} combination seen
//   fa_ref  : arithmetic reference, returns {cout, s} = a + b + cin
package fa_chk_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0] COV_ALL = 8'hFF;

  function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction

endpackage

// File: rtl/fa_response_checker_ref.sv
// Combinational golden full adder used as the checker's reference model.
//   a_i, b_i, cin_i : stimulus bits
//   sum_o           : {cout, s} expected from a correct adder
module fa_ref_model
  import fa_chk_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  output logic [1:0] sum_o
);

  assign sum_o = fa_ref(a_i, b_i, cin_i);

endmodule

// File: rtl/fa_response_checker.sv
// Response monitor for a 1-bit full adder. Each valid sample is compared with the
// reference sum; mismatches, input coverage and the first failing vector are recorded,
// and a pass/fail verdict is raised once NUM_VECTORS samples have been consumed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i             : clears statistics and (re)starts a run
//   vld_i               : a/b/cin/s/cout form a valid sample
//   a_i, b_i, cin_i     : stimulus applied to the adder
//   s_i, cout_i         : adder response
//   busy_o, done_o      : run in progress / run complete (held until next start)
//   pass_o              : verdict, valid while done_o
//   err_pulse_o         : one-cycle strobe per mismatching sample
//   err_cnt_o           : saturating mismatch count
//   vec_cnt_o           : samples consumed this run
//   coverage_o          : bit {a,b,cin} set once that combination was seen
//   first_err_idx_o     : vec_cnt value of the first mismatch
//   first_err_vec_o     : {a,b,cin,s,cout} of the first mismatch
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned ERR_W       = 8,
  localparam int unsigned VEC_W      = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             vld_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             cin_i,
  input  logic             s_i,
  input  logic             cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [VEC_W-1:0] vec_cnt_o,
  output logic [7:0]       coverage_o,
  output logic [VEC_W-1:0] first_err_idx_o,
  output logic [4:0]       first_err_vec_o
);

  localparam logic [ERR_W-1:0] ErrMax  = '1;
  localparam logic [VEC_W-1:0] LastIdx = VEC_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic             pass_q, pass_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [7:0]       cov_q, cov_d;
  logic [VEC_W-1:0] first_idx_q, first_idx_d;
  logic [4:0]       first_vec_q, first_vec_d;

  logic [1:0] exp_sum;
  logic       mismatch;

  fa_ref_model u_ref (
    .a_i   (a_i),
    .b_i   (b_i),
    .cin_i (cin_i),
    .sum_o (exp_sum)
  );

  assign mismatch = ({cout_i, s_i} != exp_sum);

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    cov_d       = cov_q;
    first_idx_d = first_idx_q;
    first_vec_d = first_vec_q;

    if (start_i) begin
      // Start wins in every state; a coincident vld is dropped.
      state_d     = StRun;
      pass_d      = 1'b0;
      err_cnt_d   = '0;
      vec_cnt_d   = '0;
      cov_d       = '0;
      first_idx_d = '0;
      first_vec_d = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (vld_i) begin
            vec_cnt_d                   = vec_cnt_q + VEC_W'(1);
            cov_d[{a_i, b_i, cin_i}]    = 1'b1;
            if (mismatch) begin
              err_pulse_d = 1'b1;
              if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ERR_W'(1);
              // err_cnt only leaves zero via the first mismatch of a run.
              if (err_cnt_q == '0) begin
                first_idx_d = vec_cnt_q;
                first_vec_d = {a_i, b_i, cin_i, s_i, cout_i};
              end
            end
            if (vec_cnt_q == LastIdx) begin
              state_d = StDone;
              pass_d  = (err_cnt_d == '0) && (cov_d == COV_ALL);
            end
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      cov_q       <= '0;
      first_idx_q <= '0;
      first_vec_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      cov_q       <= cov_d;
      first_idx_q <= first_idx_d;
      first_vec_q <= first_vec_d;
    end
  end

  assign busy_o          = (state_q == StRun);
  assign done_o          = (state_q == StDone);
  assign pass_o          = pass_q;
  assign err_pulse_o     = err_pulse_q;
  assign err_cnt_o       = err_cnt_q;
  assign vec_cnt_o       = vec_cnt_q;
  assign coverage_o      = cov_q;
  assign first_err_idx_o = first_idx_q;
  assign first_err_vec_o = first_vec_q;

endmodule
